// File: rtl/stage_fifo.sv
// stage_fifo: parametrised inter-stage FIFO with flags, occupancy count, flush and sticky overflow
// Ports: clk, reset (sync, active-high); FLUSH_S discards all entries;
//   PUSH_S/DIN_S producer write, FULL_S/ALMOST_FULL_S back-pressure;
//   POP_S consumer read, EMPTY_S/DOUT_R head entry (0 while empty);
//   COUNT_S occupancy 0..DEPTH; OVERFLOW_S sticky dropped-push flag.
module stage_fifo #(
    parameter int WIDTH       = 32,
    parameter int DEPTH       = 2,
    parameter int AFULL_LEVEL = DEPTH - 1,
    localparam int CW         = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             FLUSH_S,
    input  logic             PUSH_S,
    input  logic [WIDTH-1:0] DIN_S,
    output logic             FULL_S,
    output logic             ALMOST_FULL_S,
    input  logic             POP_S,
    output logic             EMPTY_S,
    output logic [WIDTH-1:0] DOUT_R,
    output logic [CW-1:0]    COUNT_S,
    output logic             OVERFLOW_S
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wp;
    logic [PW-1:0]    r_rp;
    logic [CW-1:0]    r_count;
    logic             r_overflow;
    logic             w_push_ok;
    logic             w_pop_ok;
    logic             w_wr;
    logic [PW-1:0]    w_wp_nxt;
    logic [PW-1:0]    w_rp_nxt;

    assign EMPTY_S       = (r_count == '0);
    assign FULL_S        = (r_count == CW'(DEPTH));
    assign ALMOST_FULL_S = (r_count >= CW'(AFULL_LEVEL));
    assign COUNT_S       = r_count;
    assign DOUT_R        = EMPTY_S ? '0 : r_mem[r_rp];
    assign OVERFLOW_S    = r_overflow;

    // a full FIFO still accepts a push when the head leaves in the same cycle
    assign w_pop_ok  = POP_S & ~EMPTY_S;
    assign w_push_ok = PUSH_S & (~FULL_S | w_pop_ok);
    assign w_wr      = w_push_ok & ~FLUSH_S & ~reset;
    assign w_wp_nxt  = (r_wp == PW'(DEPTH - 1)) ? '0 : r_wp + PW'(1);
    assign w_rp_nxt  = (r_rp == PW'(DEPTH - 1)) ? '0 : r_rp + PW'(1);

    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[r_wp] <= DIN_S;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wp       <= '0;
            r_rp       <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (FLUSH_S) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok)
                r_wp <= w_wp_nxt;
            if (w_pop_ok)
                r_rp <= w_rp_nxt;
            r_count <= r_count + CW'(w_push_ok) - CW'(w_pop_ok);
            if (PUSH_S & ~w_push_ok)
                r_overflow <= 1'b1;
        end
    end
endmodule
